// File: rtl/ncl_pkg.sv
// Shared NCL definitions: rail-pair codes and completion helpers.
package ncl_pkg;

  // Rail-pair codes, ordered {t, f}
  localparam logic [1:0] NULL    = 2'b00;
  localparam logic [1:0] DATA0   = 2'b01;
  localparam logic [1:0] DATA1   = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  // Widest dual-rail vector the helpers accept; callers zero-extend
  localparam int unsigned NCL_MAX_W = 256;

  // True when the low w bit pairs all carry DATA0 or DATA1
  function automatic logic ncl_all_data(input logic [NCL_MAX_W-1:0] t,
                                        input logic [NCL_MAX_W-1:0] f,
                                        input int unsigned w);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < NCL_MAX_W; i++) begin
      if (i < w) begin
        case ({t[i], f[i]})
          DATA0, DATA1: ok = ok;
          default:      ok = 1'b0;
        endcase
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // True when the low w bit pairs are all NULL
  function automatic logic ncl_all_null(input logic [NCL_MAX_W-1:0] t,
                                        input logic [NCL_MAX_W-1:0] f,
                                        input int unsigned w);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < NCL_MAX_W; i++) begin
      if (i < w) begin
        case ({t[i], f[i]})
          NULL:    ok = ok;
          default: ok = 1'b0;
        endcase
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // True when any of the low w bit pairs is ILLEGAL
  function automatic logic ncl_any_illegal(input logic [NCL_MAX_W-1:0] t,
                                           input logic [NCL_MAX_W-1:0] f,
                                           input int unsigned w);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NCL_MAX_W; i++) begin
      if ((i < w) && ({t[i], f[i]} == ILLEGAL)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/ncl_stage.sv
// One clocked NCL register stage: per-rail C-element with hysteresis plus
// a completion flag that follows the registered contents one edge later.
module ncl_stage
  import ncl_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic RST_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_t,
  input  logic [WIDTH-1:0] in_f,
  input  logic             ki,
  output logic [WIDTH-1:0] out_t,
  output logic [WIDTH-1:0] out_f,
  output logic             ko
);

  // A DATA reset value is all-DATA0 with the flag already requesting NULL
  localparam logic [WIDTH-1:0] RST_F  = RST_DATA ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam logic             RST_KO = ~RST_DATA;

  logic [WIDTH-1:0] t_r, f_r;
  logic [WIDTH-1:0] t_nxt_s, f_nxt_s, ld_t_s, ld_f_s;
  logic             ko_r, ko_nxt_s, all_data_s, all_null_s;

  // Each rail loads only when its input level matches the request level
  always_comb begin
    ld_t_s  = ~(in_t ^ {WIDTH{ki}});
    ld_f_s  = ~(in_f ^ {WIDTH{ki}});
    t_nxt_s = (in_t & ld_t_s) | (t_r & ~ld_t_s);
    f_nxt_s = (in_f & ld_f_s) | (f_r & ~ld_f_s);
  end

  // Completion flag: drop on a full DATA word, rise on full NULL, else hold
  always_comb begin
    all_data_s = ncl_all_data(NCL_MAX_W'(t_r), NCL_MAX_W'(f_r), WIDTH);
    all_null_s = ncl_all_null(NCL_MAX_W'(t_r), NCL_MAX_W'(f_r), WIDTH);
    if (all_data_s) begin
      ko_nxt_s = 1'b0;
    end else if (all_null_s) begin
      ko_nxt_s = 1'b1;
    end else begin
      ko_nxt_s = ko_r;
    end
  end

  // Rail registers and completion flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_r  <= {WIDTH{1'b0}};
      f_r  <= RST_F;
      ko_r <= RST_KO;
    end else begin
      t_r  <= t_nxt_s;
      f_r  <= f_nxt_s;
      ko_r <= ko_nxt_s;
    end
  end

  assign out_t = t_r;
  assign out_f = f_r;
  assign ko    = ko_r;

endmodule

// File: rtl/ncl_pipe_reg.sv
// Clocked NCL pipeline of DEPTH dual-rail stages with an illegal-code
// sticky flag and a count of DATA wavefronts completed at the output.
module ncl_pipe_reg
  import ncl_pkg::*;
#(
  parameter int             WIDTH    = 8,
  parameter int             DEPTH    = 3,
  parameter logic [DEPTH-1:0] RST_DATA = {DEPTH{1'b0}},
  parameter int             CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_t,
  input  logic [WIDTH-1:0] in_f,
  output logic             ko,
  output logic [WIDTH-1:0] out_t,
  output logic [WIDTH-1:0] out_f,
  input  logic             ki,
  output logic             err,
  output logic [CNT_W-1:0] tok_cnt
);

  // Two adjacent DATA stages would hold a wavefront with no NULL spacer
  if (DEPTH < 1) begin : g_bad_depth
    $error("ncl_pipe_reg: DEPTH must be at least 1");
  end
  if ((RST_DATA & (RST_DATA >> 1)) != {DEPTH{1'b0}}) begin : g_bad_rst_data
    $error("ncl_pipe_reg: RST_DATA must not have two adjacent bits set");
  end
  if (WIDTH > int'(NCL_MAX_W)) begin : g_bad_width
    $error("ncl_pipe_reg: WIDTH exceeds the helper limit");
  end

  // Element s feeds stage s; element DEPTH is the pipe output
  logic [WIDTH-1:0] chain_t_s  [DEPTH+1];
  logic [WIDTH-1:0] chain_f_s  [DEPTH+1];
  // Element s is stage s's flag; element DEPTH is the downstream request
  logic             ko_chain_s [DEPTH+1];

  logic             err_r, err_nxt_s, illegal_s, tok_inc_s;
  logic [CNT_W-1:0] tok_cnt_r, tok_nxt_s;

  assign chain_t_s[0]      = in_t;
  assign chain_f_s[0]      = in_f;
  assign ko_chain_s[DEPTH] = ki;

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    ncl_stage #(
      .WIDTH    (WIDTH),
      .RST_DATA (RST_DATA[s])
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .in_t  (chain_t_s[s]),
      .in_f  (chain_f_s[s]),
      .ki    (ko_chain_s[s+1]),
      .out_t (chain_t_s[s+1]),
      .out_f (chain_f_s[s+1]),
      .ko    (ko_chain_s[s])
    );
  end

  // Sticky error and token counting; a token completes when the last
  // stage's flag is about to fall, so a reset-DATA stage never counts
  always_comb begin
    illegal_s = ncl_any_illegal(NCL_MAX_W'(in_t), NCL_MAX_W'(in_f), WIDTH);
    tok_inc_s = ko_chain_s[DEPTH-1] &
                ncl_all_data(NCL_MAX_W'(chain_t_s[DEPTH]), NCL_MAX_W'(chain_f_s[DEPTH]), WIDTH);
    if (illegal_s) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = err_r;
    end
    if (tok_inc_s) begin
      tok_nxt_s = tok_cnt_r + CNT_W'(1'b1);
    end else begin
      tok_nxt_s = tok_cnt_r;
    end
  end

  // Error flag and token counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r     <= 1'b0;
      tok_cnt_r <= {CNT_W{1'b0}};
    end else begin
      err_r     <= err_nxt_s;
      tok_cnt_r <= tok_nxt_s;
    end
  end

  assign ko      = ko_chain_s[0];
  assign out_t   = chain_t_s[DEPTH];
  assign out_f   = chain_f_s[DEPTH];
  assign err     = err_r;
  assign tok_cnt = tok_cnt_r;

endmodule

// File: tb/tb_ncl_pipe_reg.sv
// Directed bench for ncl_pipe_reg (WIDTH=8, DEPTH=3) with a wavefront
// scoreboard; dut0 resets all NULL, dut1 resets stage 1 to DATA.
module tb_ncl_pipe_reg;

  logic       clk = 1'b0;
  logic       rst0_n, rst1_n;
  logic [7:0] in_t, in_f;
  logic       ki;

  logic       ko0, err0, ko1, err1;
  logic [7:0] out_t0, out_f0, out_t1, out_f1;
  logic [15:0] tok0, tok1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] exp_q  [$];
  logic [15:0] send_q [$];
  logic        up_en   = 1'b0;
  logic        up_data = 1'b0;

  ncl_pipe_reg #(.WIDTH(8), .DEPTH(3), .RST_DATA(3'b000), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst0_n), .in_t(in_t), .in_f(in_f), .ko(ko0),
    .out_t(out_t0), .out_f(out_f0), .ki(ki), .err(err0), .tok_cnt(tok0));

  ncl_pipe_reg #(.WIDTH(8), .DEPTH(3), .RST_DATA(3'b010), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst1_n), .in_t(in_t), .in_f(in_f), .ko(ko1),
    .out_t(out_t1), .out_f(out_f1), .ki(ki), .err(err1), .tok_cnt(tok1));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Compare dut0's output word against the oldest wavefront sent
  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) begin
      n_chk++;
      $error("FAIL %s: observed 0x%0h expected a queued wavefront (queue empty)", tag, {out_t0, out_f0});
    end else begin
      chk(tag, {16'h0000, out_t0, out_f0}, {16'h0000, exp_q.pop_front()});
    end
  endtask

  // Upstream source: NULL once ko=0, next queued DATA once ko=1
  task automatic upstream();
    logic [15:0] w;
    if (up_en) begin
      if (!ko0 && up_data) begin
        in_t = 8'h00; in_f = 8'h00; up_data = 1'b0;
      end else if (ko0 && !up_data && send_q.size() > 0) begin
        w = send_q.pop_front();
        in_t = w[15:8]; in_f = w[7:0]; up_data = 1'b1;
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    upstream();
  endtask

  // Reset dut0 between edges and release on the falling edge
  task automatic reset_pipe();
    rst0_n = 1'b0;
    in_t = 8'h00; in_f = 8'h00;
    up_en = 1'b0; up_data = 1'b0;
    exp_q.delete(); send_q.delete();
    @(negedge clk);
    rst0_n = 1'b1;
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    in_t = 8'h00; in_f = 8'h00; ki = 1'b1;

    // Reset state
    #12;
    chk("rst_out", {16'h0000, out_t0, out_f0}, 32'h0000_0000);
    chk("rst_ko", {31'd0, ko0}, 32'd1);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_tok", {16'h0000, tok0}, 32'd0);
    @(negedge clk);
    rst0_n = 1'b1; rst1_n = 1'b1;

    // Latency through an empty pipe
    ki = 1'b1;
    send_q.push_back(16'hA55A);
    up_en = 1'b1;
    upstream();
    step();
    chk("lat_ko_e1", {31'd0, ko0}, 32'd1);
    step();
    chk("lat_ko_e2", {31'd0, ko0}, 32'd0);
    step();
    pop_chk("lat_out_e3");
    step();
    chk("lat_tok_e4", {16'h0000, tok0}, 32'd1);

    // Backpressure: two wavefronts, downstream request toggled by hand
    reset_pipe();
    ki = 1'b0;
    send_q.push_back(16'h11EE);
    send_q.push_back(16'h22DD);
    up_en = 1'b1;
    upstream();
    repeat (8) step();
    chk("bp_stall_out", {16'h0000, out_t0, out_f0}, 32'h0000_0000);
    chk("bp_stall_s1", {16'h0000, dut0.g_stage[1].u_stage.out_t, dut0.g_stage[1].u_stage.out_f}, 32'h0000_11EE);
    chk("bp_stall_tok", {16'h0000, tok0}, 32'd0);
    ki = 1'b1;
    repeat (8) step();
    pop_chk("bp_out_11");
    chk("bp_ko_low", {31'd0, ko0}, 32'd0);
    chk("bp_tok_1", {16'h0000, tok0}, 32'd1);
    ki = 1'b0;
    repeat (8) step();
    chk("bp_out_null", {16'h0000, out_t0, out_f0}, 32'h0000_0000);
    chk("bp_tok_hold", {16'h0000, tok0}, 32'd1);
    ki = 1'b1;
    repeat (4) step();
    pop_chk("bp_out_22");
    chk("bp_tok_2", {16'h0000, tok0}, 32'd2);
    chk("bp_no_dup", exp_q.size(), 32'd0);

    // Partial wavefront latches bitwise but completion waits
    reset_pipe();
    ki = 1'b1;
    in_t = 8'h0F; in_f = 8'h00;
    repeat (3) step();
    chk("part_latch", {16'h0000, out_t0, out_f0}, 32'h0000_0F00);
    chk("part_ko_hold", {31'd0, ko0}, 32'd1);
    in_f = 8'hF0;
    exp_q.push_back(16'h0FF0);
    step();
    chk("part_ko_e1", {31'd0, ko0}, 32'd1);
    step();
    chk("part_ko_e2", {31'd0, ko0}, 32'd0);
    step();
    pop_chk("part_out");

    // Illegal code sets the sticky error without masking the register
    reset_pipe();
    ki = 1'b1;
    in_t = 8'h04; in_f = 8'h04;
    #1;
    chk("err_pre_edge", {31'd0, err0}, 32'd0);
    step();
    chk("err_set", {31'd0, err0}, 32'd1);
    chk("err_no_mask", {16'h0000, dut0.g_stage[0].u_stage.out_t, dut0.g_stage[0].u_stage.out_f}, 32'h0000_0404);
    in_t = 8'h00; in_f = 8'h00;
    repeat (3) step();
    chk("err_sticky", {31'd0, err0}, 32'd1);

    // Reset-DATA stage: reset values, token movement, mid-traffic reset
    rst1_n = 1'b0;
    in_t = 8'h00; in_f = 8'h00; ki = 1'b1;
    #1;
    chk("rd_rst_s1", {16'h0000, dut1.g_stage[1].u_stage.out_t, dut1.g_stage[1].u_stage.out_f}, 32'h0000_00FF);
    chk("rd_rst_ko", {31'd0, ko1}, 32'd1);
    @(negedge clk);
    rst1_n = 1'b1;
    step();
    chk("rd_token_out", {16'h0000, out_t1, out_f1}, 32'h0000_00FF);
    in_t = 8'h3C; in_f = 8'hC3;
    repeat (3) step();
    #2;
    rst1_n = 1'b0;
    #1;
    chk("rd_mid_s0", {16'h0000, dut1.g_stage[0].u_stage.out_t, dut1.g_stage[0].u_stage.out_f}, 32'h0000_0000);
    chk("rd_mid_s1", {16'h0000, dut1.g_stage[1].u_stage.out_t, dut1.g_stage[1].u_stage.out_f}, 32'h0000_00FF);
    chk("rd_mid_s2", {16'h0000, out_t1, out_f1}, 32'h0000_0000);
    chk("rd_mid_tok", {16'h0000, tok1}, 32'd0);
    chk("rd_mid_err", {31'd0, err1}, 32'd0);
    @(negedge clk);
    rst1_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
